// File: rtl/levit_stage_sequencer_if.sv
// Control bundle between the LeViT stage sequencer and the shared datapath:
// the job request in, the load/run strobes and status out.
interface levit_stage_sequencer_if;
  logic       en;
  logic       conv16_wload;
  logic       conv8_wload;
  logic       conv4_wload;
  logic [1:0] wrow_idx;
  logic       conv16_run;
  logic       conv8_run;
  logic       conv4_run;
  logic       att_run;
  logic       bias_load;
  logic       end_sig;
  logic       busy;
  logic [2:0] stage;

  // Sequencer side: takes the request, drives the datapath enables.
  modport master (
    input  en,
    output conv16_wload, conv8_wload, conv4_wload, wrow_idx,
    output conv16_run, conv8_run, conv4_run, att_run,
    output bias_load, end_sig, busy, stage
  );

  // Requester/datapath side.
  modport slave (
    output en,
    input  conv16_wload, conv8_wload, conv4_wload, wrow_idx,
    input  conv16_run, conv8_run, conv4_run, att_run,
    input  bias_load, end_sig, busy, stage
  );
endinterface

// File: rtl/levit_stage_sequencer.sv
// Tiny LeViT top-level sequencer: loads and runs conv16, conv8, conv4, then attention,
// from one level request. Outputs are a registered decode of the current state/counter.
module levit_stage_sequencer #(
  parameter int KROWS = 3,
  parameter int RUN16 = 8,
  parameter int RUN8  = 6,
  parameter int RUN4  = 4,
  parameter int ATT   = 4,
  parameter int CW    = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  levit_stage_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_LD16  = 4'd1,
    S_RUN16 = 4'd2,
    S_LD8   = 4'd3,
    S_RUN8  = 4'd4,
    S_LD4   = 4'd5,
    S_RUN4  = 4'd6,
    S_ATT   = 4'd7,
    S_DONE  = 4'd8
  } state_e;

  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] LAST_LD   = CW'(KROWS - 1);
  localparam logic [CW-1:0] LAST_R16  = CW'(RUN16 - 1);
  localparam logic [CW-1:0] LAST_R8   = CW'(RUN8 - 1);
  localparam logic [CW-1:0] LAST_R4   = CW'(RUN4 - 1);
  localparam logic [CW-1:0] LAST_ATT  = CW'(ATT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic          last_s;

  logic          conv16_wload_q, conv16_wload_d;
  logic          conv8_wload_q, conv8_wload_d;
  logic          conv4_wload_q, conv4_wload_d;
  logic [1:0]    wrow_idx_q, wrow_idx_d;
  logic          conv16_run_q, conv16_run_d;
  logic          conv8_run_q, conv8_run_d;
  logic          conv4_run_q, conv4_run_d;
  logic          att_run_q, att_run_d;
  logic          bias_load_q, bias_load_d;
  logic          end_sig_q, end_sig_d;
  logic          busy_q, busy_d;
  logic [2:0]    stage_q, stage_d;

  function automatic state_e next_stage(input state_e s);
    case (s)
      S_LD16:  next_stage = S_RUN16;
      S_RUN16: next_stage = S_LD8;
      S_LD8:   next_stage = S_RUN8;
      S_RUN8:  next_stage = S_LD4;
      S_LD4:   next_stage = S_RUN4;
      S_RUN4:  next_stage = S_ATT;
      S_ATT:   next_stage = S_DONE;
      default: next_stage = S_IDLE;
    endcase
  endfunction

  // Detect the final cycle of the current state.
  always_comb begin
    last_s = 1'b0;
    case (state_q)
      S_LD16, S_LD8, S_LD4: last_s = (cnt_q == LAST_LD);
      S_RUN16:              last_s = (cnt_q == LAST_R16);
      S_RUN8:               last_s = (cnt_q == LAST_R8);
      S_RUN4:               last_s = (cnt_q == LAST_R4);
      S_ATT:                last_s = (cnt_q == LAST_ATT);
      S_DONE:               last_s = 1'b1;
      default:              last_s = 1'b0;
    endcase
  end

  // Next state, counter and re-arm flag; a held-high en cannot start a second job.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_ONE;
    armed_d = armed_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = CNT_ZERO;
        if (!bus.en) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = S_LD16;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
      default: begin
        if (!bus.en) begin
          state_d = S_IDLE;
          cnt_d   = CNT_ZERO;
          armed_d = 1'b1;
        end else if (last_s) begin
          state_d = next_stage(state_q);
          cnt_d   = CNT_ZERO;
          armed_d = (next_stage(state_q) == S_DONE) ? 1'b0 : armed_q;
        end else begin
          state_d = state_q;
        end
      end
    endcase
  end

  // Output decode of the present state; registered so en never reaches an output combinationally.
  always_comb begin
    conv16_wload_d = (state_q == S_LD16);
    conv8_wload_d  = (state_q == S_LD8);
    conv4_wload_d  = (state_q == S_LD4);
    wrow_idx_d     = (conv16_wload_d || conv8_wload_d || conv4_wload_d) ? cnt_q[1:0] : 2'd0;
    conv16_run_d   = (state_q == S_RUN16);
    conv8_run_d    = (state_q == S_RUN8);
    conv4_run_d    = (state_q == S_RUN4);
    att_run_d      = (state_q == S_ATT);
    bias_load_d    = (state_q == S_ATT) && (cnt_q == CNT_ZERO);
    end_sig_d      = (state_q == S_DONE);
    busy_d         = (state_q != S_IDLE);
    stage_d        = (state_q == S_DONE) ? 3'd0 : state_q[2:0];
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= S_IDLE;
      cnt_q          <= CNT_ZERO;
      armed_q        <= 1'b1;
      conv16_wload_q <= 1'b0;
      conv8_wload_q  <= 1'b0;
      conv4_wload_q  <= 1'b0;
      wrow_idx_q     <= 2'd0;
      conv16_run_q   <= 1'b0;
      conv8_run_q    <= 1'b0;
      conv4_run_q    <= 1'b0;
      att_run_q      <= 1'b0;
      bias_load_q    <= 1'b0;
      end_sig_q      <= 1'b0;
      busy_q         <= 1'b0;
      stage_q        <= 3'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      armed_q        <= armed_d;
      conv16_wload_q <= conv16_wload_d;
      conv8_wload_q  <= conv8_wload_d;
      conv4_wload_q  <= conv4_wload_d;
      wrow_idx_q     <= wrow_idx_d;
      conv16_run_q   <= conv16_run_d;
      conv8_run_q    <= conv8_run_d;
      conv4_run_q    <= conv4_run_d;
      att_run_q      <= att_run_d;
      bias_load_q    <= bias_load_d;
      end_sig_q      <= end_sig_d;
      busy_q         <= busy_d;
      stage_q        <= stage_d;
    end
  end

  assign bus.conv16_wload = conv16_wload_q;
  assign bus.conv8_wload  = conv8_wload_q;
  assign bus.conv4_wload  = conv4_wload_q;
  assign bus.wrow_idx     = wrow_idx_q;
  assign bus.conv16_run   = conv16_run_q;
  assign bus.conv8_run    = conv8_run_q;
  assign bus.conv4_run    = conv4_run_q;
  assign bus.att_run      = att_run_q;
  assign bus.bias_load    = bias_load_q;
  assign bus.end_sig      = end_sig_q;
  assign bus.busy         = busy_q;
  assign bus.stage        = stage_q;

endmodule

// File: tb/tb_levit_stage_sequencer.sv
// Directed bench for levit_stage_sequencer: full jobs, re-arm, abort, async reset,
// and a shortened-parameter instance, with per-cycle one-hot/busy invariants.
module tb_levit_stage_sequencer;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_err;
  int   n_end;

  levit_stage_sequencer_if bus();
  levit_stage_sequencer_if bus2();

  levit_stage_sequencer dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  levit_stage_sequencer #(
    .KROWS (2),
    .RUN16 (1),
    .RUN8  (1),
    .RUN4  (1),
    .ATT   (1),
    .CW    (4)
  ) dut2 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {w16,w8,w4,wrow[1:0],r16,r8,r4,att,bias,end,busy,stage[2:0]}
  function automatic logic [14:0] pk(input logic w16, input logic w8, input logic w4,
                                     input logic [1:0] wr, input logic r16, input logic r8,
                                     input logic r4, input logic ra, input logic bl,
                                     input logic es, input logic by, input logic [2:0] st);
    return {w16, w8, w4, wr, r16, r8, r4, ra, bl, es, by, st};
  endfunction

  function automatic logic [14:0] obs1();
    return pk(bus.conv16_wload, bus.conv8_wload, bus.conv4_wload, bus.wrow_idx,
              bus.conv16_run, bus.conv8_run, bus.conv4_run, bus.att_run,
              bus.bias_load, bus.end_sig, bus.busy, bus.stage);
  endfunction

  function automatic logic [14:0] obs2();
    return pk(bus2.conv16_wload, bus2.conv8_wload, bus2.conv4_wload, bus2.wrow_idx,
              bus2.conv16_run, bus2.conv8_run, bus2.conv4_run, bus2.att_run,
              bus2.bias_load, bus2.end_sig, bus2.busy, bus2.stage);
  endfunction

  // Expected outputs k edges after the sampling edge E0, laid out on the job timeline.
  function automatic logic [14:0] exp_job(input int k, input int kr, input int r16,
                                          input int r8, input int r4, input int at);
    int t;
    t = k - 1;
    if (t < 0) return 15'd0;
    if (t < kr) return pk(1'b1, 1'b0, 1'b0, 2'(t), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
    t = t - kr;
    if (t < r16) return pk(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
    t = t - r16;
    if (t < kr) return pk(1'b0, 1'b1, 1'b0, 2'(t), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3);
    t = t - kr;
    if (t < r8) return pk(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4);
    t = t - r8;
    if (t < kr) return pk(1'b0, 1'b0, 1'b1, 2'(t), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5);
    t = t - kr;
    if (t < r4) return pk(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6);
    t = t - r4;
    if (t < at) return pk(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, (t == 0), 1'b0, 1'b1, 3'd7);
    t = t - at;
    if (t == 0) return pk(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
    return 15'd0;
  endfunction

  // Advance one clock, sample 1 ns later, and check the per-cycle invariants on both instances.
  task automatic step();
    @(posedge clk);
    #1;
    chk("onehot1", 32'($countones({bus.conv16_wload, bus.conv8_wload, bus.conv4_wload,
        bus.conv16_run, bus.conv8_run, bus.conv4_run, bus.att_run}) <= 1), 32'd1);
    chk("busy1", 32'(bus.busy), 32'((bus.stage != 3'd0) || bus.end_sig));
    chk("onehot2", 32'($countones({bus2.conv16_wload, bus2.conv8_wload, bus2.conv4_wload,
        bus2.conv16_run, bus2.conv8_run, bus2.conv4_run, bus2.att_run}) <= 1), 32'd1);
    chk("busy2", 32'(bus2.busy), 32'((bus2.stage != 3'd0) || bus2.end_sig));
  endtask

  task automatic run_job(input string tag, input int kmax);
    for (int k = 0; k <= kmax; k++) begin
      step();
      chk($sformatf("%s_e%0d", tag, k), 32'(obs1()), 32'(exp_job(k, 3, 8, 6, 4, 4)));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_end = 0;
    rstn = 1'b0;
    bus.en = 1'b0;
    bus2.en = 1'b0;
    #12;
    chk("rst_out1", 32'(obs1()), 32'd0);
    chk("rst_out2", 32'(obs2()), 32'd0);
    step();
    step();
    rstn = 1'b1;
    step();
    chk("rst_idle", 32'(obs1()), 32'd0);

    // 1: full job with en held high for 40 cycles
    bus.en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      chk($sformatf("s1_e%0d", k), 32'(obs1()), 32'(exp_job(k, 3, 8, 6, 4, 4)));
      if (bus.end_sig) n_end++;
      if (k == 32) chk("s1_end_e32", 32'(bus.end_sig), 32'd1);
      if (k == 33) chk("s1_busy_e33", 32'(bus.busy), 32'd0);
    end
    chk("s1_end_count", 32'(n_end), 32'd1);

    // 2: held-high en does not restart; one low cycle re-arms
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("s2_hold%0d", k), 32'(obs1()), 32'd0);
    end
    bus.en = 1'b0;
    step();
    chk("s2_low", 32'(obs1()), 32'd0);
    bus.en = 1'b1;
    run_job("s2", 33);

    // 3: abort during RUN8
    bus.en = 1'b0;
    step();
    bus.en = 1'b1;
    run_job("s3", 15);
    bus.en = 1'b0;
    step();
    chk("s3_e16_run8", 32'(obs1()), 32'(exp_job(16, 3, 8, 6, 4, 4)));
    for (int k = 17; k < 22; k++) begin
      step();
      chk($sformatf("s3_abort_e%0d", k), 32'(obs1()), 32'd0);
    end
    bus.en = 1'b1;

    // 4: restart after abort, then async reset mid-LD4
    run_job("s4", 22);
    #2;
    rstn = 1'b0;
    #1;
    chk("s4_async_rst", 32'(obs1()), 32'd0);
    step();
    rstn = 1'b1;
    run_job("s4r", 34);

    // 5: shortened-parameter instance
    bus.en = 1'b0;
    bus2.en = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      chk($sformatf("s5_e%0d", k), 32'(obs2()), 32'(exp_job(k, 2, 1, 1, 1, 1)));
      chk($sformatf("s5_end_e%0d", k), 32'(bus2.end_sig), 32'(k == 11));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/levit_stage_sequencer.md
Name: levit_stage_sequencer

Overview:
Top-level control FSM for the Tiny LeViT accelerator. It loads the 3-row filter kernel for each conv stage in turn (conv16 -> conv8 -> conv4), runs that stage for a fixed number of cycles, then runs the attention stage and pulses end_sig. It drives the load and run enables of the shared datapath from one en input, replacing hand-timed stimulus.

Parameters:
KROWS, 3, filter rows loaded per conv stage (one row per cycle)
RUN16, 8, conv16 compute cycles
RUN8, 6, conv8 compute cycles
RUN4, 4, conv4 compute cycles
ATT, 4, attention compute cycles
CW, 4, internal cycle-counter width; must hold max(KROWS, RUN16, RUN8, RUN4, ATT)-1

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
en  in  1  level run request; must be held high for the whole job
conv16_wload  out  1  conv16 filter-row load strobe
conv8_wload  out  1  conv8 filter-row load strobe
conv4_wload  out  1  conv4 filter-row load strobe
wrow_idx  out  2  filter row being loaded, 0..KROWS-1; 0 when no load is active
conv16_run  out  1  conv16 compute enable
conv8_run  out  1  conv8 compute enable
conv4_run  out  1  conv4 compute enable
att_run  out  1  attention compute enable
bias_load  out  1  one-cycle strobe that captures the bias into the attention unit
end_sig  out  1  one-cycle job-complete pulse
busy  out  1  high in every state except IDLE
stage  out  3  state encoding for debug

Behaviour:
- Clock and reset: one clock, clk. Reset is rstn, asynchronous and active-low.
- Reset: state=IDLE, counter=0, all outputs 0.
- All outputs are registered (Moore) and decoded from state/counter. No combinational path from en to any output.
- State encoding (stage): IDLE=0, LD16=1, RUN16=2, LD8=3, RUN8=4, LD4=5, RUN4=6, ATT=7. DONE reuses 0 with end_sig=1.
- IDLE -> LD16 when en=1 and armed=1. armed is cleared on entry to DONE and set whenever en=0 is sampled in IDLE. A held-high en therefore never restarts a job.
- The counter clears on every state entry and increments each cycle. A state exits when counter == length-1.
  - Lengths: LDx = KROWS; RUN16/RUN8/RUN4 = RUN16/RUN8/RUN4; ATT = ATT; DONE = 1.
- Transitions: LD16 -> RUN16 -> LD8 -> RUN8 -> LD4 -> RUN4 -> ATT -> DONE -> IDLE.
- In LDx: the matching convX_wload=1 and wrow_idx=counter (0,1,2).
- In RUNx: the matching convX_run=1.
- In ATT: att_run=1. bias_load=1 only while counter==0.
- In DONE: end_sig=1 for exactly one cycle; busy=1.
- Abort: en=0 sampled in any state other than IDLE or DONE -> next state is IDLE.
  - All enables drop in the same cycle IDLE is entered; no end_sig.
  - armed is set, so the next en=1 restarts from LD16.
- At most one of the *_wload/*_run/att_run signals is high in any cycle.
- Latency with defaults: the first en=1 sampling edge is E0.
  - LD16 covers E1-E3, RUN16 E4-E11, LD8 E12-E14, RUN8 E15-E20, LD4 E21-E23, RUN4 E24-E27, ATT E28-E31.
  - DONE (end_sig=1) is E32; IDLE from E33.
- Reset asserted mid-operation: immediate return to reset values, armed=1.

Test Plan:
1. Reset, then en=1 held 40 cycles -> conv16_wload high 3 cycles with wrow_idx 0,1,2; conv16_run 8 cycles; conv8 load 3 + run 6; conv4 load 3 + run 4; att_run 4 with bias_load on the first; end_sig a single pulse at E32; busy low from E33.
2. Continue holding en=1 after scenario 1 for 20 cycles -> stays in IDLE, no strobes. Drop en for 1 cycle, raise it -> new job starts, end_sig 32 edges after the sampling edge.
3. Drop en to 0 at E16 (during RUN8) -> IDLE at E17, all enables 0, no end_sig. Re-raise en -> starts from LD16 with wrow_idx=0.
4. Assert rstn=0 asynchronously mid-LD4 -> all outputs 0 immediately without a clock edge. Release with en=1 -> full job from LD16.
5. Parameter override KROWS=2, RUN16=1, RUN8=1, RUN4=1, ATT=1 -> wrow_idx sequence 0,1 per stage; end_sig at E11.
6. Every cycle of scenarios 1-5 -> one-hot check: popcount(wload, run, att_run signals) <= 1; busy == (stage != 0 || end_sig).
